// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader
//  Purpose  : Receives a framed program image over a UART byte stream
//             (SYNC, 4-byte LE length, payload, XOR checksum) and writes the
//             payload into memory through an AXI4-Lite write master. The CPU
//             core is held in reset until the image is written and verified.
//             Port rst is an asynchronous, active-low reset.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int unsigned MAX_BYTES = 65536,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [63:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [63:0] wdata,
   output logic [7:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic        cpu_hold,
   output logic        boot_done,
   output logic        boot_error
);

   localparam logic [31:0] c_max_len = 32'(MAX_BYTES);

   typedef enum logic [2:0] {
      S_SYNC    = 3'd0,
      S_LEN     = 3'd1,
      S_DATA    = 3'd2,
      S_WR_ADDR = 3'd3,
      S_WR_RESP = 3'd4,
      S_CHECK   = 3'd5,
      S_DONE    = 3'd6,
      S_ERROR   = 3'd7
   } state_t;

   state_t      r_state,      w_state_nxt;
   logic [31:0] r_len,        w_len_nxt;
   logic [1:0]  r_len_cnt,    w_len_cnt_nxt;
   logic [31:0] r_byte_cnt,   w_byte_cnt_nxt;
   logic [31:0] r_word_idx,   w_word_idx_nxt;
   logic [7:0]  r_csum,       w_csum_nxt;
   logic [63:0] r_wdata,      w_wdata_nxt;
   logic [7:0]  r_wstrb,      w_wstrb_nxt;
   logic        r_awvalid,    w_awvalid_nxt;
   logic        r_wvalid,     w_wvalid_nxt;
   logic        r_aw_done,    w_aw_done_nxt;
   logic        r_w_done,     w_w_done_nxt;
   logic        r_bready,     w_bready_nxt;
   logic        r_cpu_hold,   w_cpu_hold_nxt;
   logic        r_boot_done,  w_boot_done_nxt;
   logic        r_boot_error, w_boot_error_nxt;

   logic        w_rx_fire;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic [2:0]  w_lane;
   logic [31:0] w_len_full;
   logic [31:0] w_byte_cnt_inc;

   // RX is only accepted in the byte-consuming states and never during reset,
   // so no AXI write can overlap an RX acceptance
   always_comb begin
      rx_ready = 1'b0;
      if (rst) begin
         case (r_state)
            S_SYNC, S_LEN, S_DATA, S_CHECK: rx_ready = 1'b1;
            default:                        rx_ready = 1'b0;
         endcase
      end
   end

   assign w_rx_fire      = rx_valid & rx_ready;
   assign w_aw_hs        = r_awvalid & awready;
   assign w_w_hs         = r_wvalid & wready;
   assign w_lane         = r_byte_cnt[2:0];
   assign w_len_full     = {rx_data, r_len[31:8]};
   assign w_byte_cnt_inc = r_byte_cnt + 32'd1;

   assign awaddr     = BASE_ADDR + {29'd0, r_word_idx, 3'd0};
   assign awvalid    = r_awvalid;
   assign wdata      = r_wdata;
   assign wstrb      = r_wstrb;
   assign wvalid     = r_wvalid;
   assign bready     = r_bready;
   assign cpu_hold   = r_cpu_hold;
   assign boot_done  = r_boot_done;
   assign boot_error = r_boot_error;

   // State register and all datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_SYNC;
         r_len        <= 32'd0;
         r_len_cnt    <= 2'd0;
         r_byte_cnt   <= 32'd0;
         r_word_idx   <= 32'd0;
         r_csum       <= 8'd0;
         r_wdata      <= 64'd0;
         r_wstrb      <= 8'd0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
         r_bready     <= 1'b0;
         r_cpu_hold   <= 1'b1;
         r_boot_done  <= 1'b0;
         r_boot_error <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_len        <= w_len_nxt;
         r_len_cnt    <= w_len_cnt_nxt;
         r_byte_cnt   <= w_byte_cnt_nxt;
         r_word_idx   <= w_word_idx_nxt;
         r_csum       <= w_csum_nxt;
         r_wdata      <= w_wdata_nxt;
         r_wstrb      <= w_wstrb_nxt;
         r_awvalid    <= w_awvalid_nxt;
         r_wvalid     <= w_wvalid_nxt;
         r_aw_done    <= w_aw_done_nxt;
         r_w_done     <= w_w_done_nxt;
         r_bready     <= w_bready_nxt;
         r_cpu_hold   <= w_cpu_hold_nxt;
         r_boot_done  <= w_boot_done_nxt;
         r_boot_error <= w_boot_error_nxt;
      end
   end

   // Next-state and next-output logic for the frame parser and AXI master
   always_comb begin
      w_state_nxt      = r_state;
      w_len_nxt        = r_len;
      w_len_cnt_nxt    = r_len_cnt;
      w_byte_cnt_nxt   = r_byte_cnt;
      w_word_idx_nxt   = r_word_idx;
      w_csum_nxt       = r_csum;
      w_wdata_nxt      = r_wdata;
      w_wstrb_nxt      = r_wstrb;
      w_awvalid_nxt    = r_awvalid;
      w_wvalid_nxt     = r_wvalid;
      w_aw_done_nxt    = r_aw_done;
      w_w_done_nxt     = r_w_done;
      w_bready_nxt     = r_bready;
      w_cpu_hold_nxt   = r_cpu_hold;
      w_boot_done_nxt  = r_boot_done;
      w_boot_error_nxt = r_boot_error;

      case (r_state)
         S_SYNC: begin
            // Non-sync bytes are simply dropped
            if (w_rx_fire && (rx_data == SYNC_BYTE)) begin
               w_state_nxt    = S_LEN;
               w_len_nxt      = 32'd0;
               w_len_cnt_nxt  = 2'd0;
               w_byte_cnt_nxt = 32'd0;
               w_word_idx_nxt = 32'd0;
               w_csum_nxt     = 8'd0;
               w_wdata_nxt    = 64'd0;
               w_wstrb_nxt    = 8'd0;
            end
         end

         S_LEN: begin
            // Length arrives LSB first; shifting right leaves byte 0 at [7:0]
            if (w_rx_fire) begin
               w_len_nxt     = w_len_full;
               w_len_cnt_nxt = r_len_cnt + 2'd1;
               if (r_len_cnt == 2'd3) begin
                  if (w_len_full == 32'd0) begin
                     w_state_nxt = S_CHECK;
                  end else if (w_len_full > c_max_len) begin
                     w_state_nxt      = S_ERROR;
                     w_boot_error_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_DATA;
                  end
               end
            end
         end

         S_DATA: begin
            if (w_rx_fire) begin
               w_wdata_nxt[{w_lane, 3'b000} +: 8] = rx_data;
               w_wstrb_nxt[w_lane]                = 1'b1;
               w_csum_nxt                         = r_csum ^ rx_data;
               w_byte_cnt_nxt                     = w_byte_cnt_inc;
               // Flush on a full word or on the final payload byte
               if ((w_lane == 3'd7) || (w_byte_cnt_inc == r_len)) begin
                  w_state_nxt   = S_WR_ADDR;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_aw_done_nxt = 1'b0;
                  w_w_done_nxt  = 1'b0;
               end
            end
         end

         S_WR_ADDR: begin
            // AW and W channels complete independently, in any order
            if (w_aw_hs) begin
               w_awvalid_nxt = 1'b0;
               w_aw_done_nxt = 1'b1;
            end
            if (w_w_hs) begin
               w_wvalid_nxt = 1'b0;
               w_w_done_nxt = 1'b1;
            end
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
               w_state_nxt   = S_WR_RESP;
               w_bready_nxt  = 1'b1;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
            end
         end

         S_WR_RESP: begin
            if (r_bready && bvalid) begin
               w_bready_nxt = 1'b0;
               if (bresp != 2'b00) begin
                  w_state_nxt      = S_ERROR;
                  w_boot_error_nxt = 1'b1;
               end else begin
                  w_word_idx_nxt = r_word_idx + 32'd1;
                  w_wstrb_nxt    = 8'd0;
                  w_wdata_nxt    = 64'd0;
                  w_state_nxt    = (r_byte_cnt == r_len) ? S_CHECK : S_DATA;
               end
            end
         end

         S_CHECK: begin
            if (w_rx_fire) begin
               if (rx_data == r_csum) begin
                  w_state_nxt     = S_DONE;
                  w_cpu_hold_nxt  = 1'b0;
                  w_boot_done_nxt = 1'b1;
               end else begin
                  w_state_nxt      = S_ERROR;
                  w_boot_error_nxt = 1'b1;
               end
            end
         end

         S_DONE: begin
            w_cpu_hold_nxt  = 1'b0;
            w_boot_done_nxt = 1'b1;
         end

         S_ERROR: begin
            w_cpu_hold_nxt   = 1'b1;
            w_boot_error_nxt = 1'b1;
         end

         default: begin
            w_state_nxt = S_ERROR;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_boot_loader
//  Purpose  : Directed self-checking bench for uart_boot_loader with a small
//             AXI4-Lite write slave that logs every AW and W handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

   localparam logic [63:0] BASE = 64'h0000_0001_8000_0000;
   localparam int unsigned MAXB = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [63:0] awaddr;
   logic        awvalid;
   logic        awready = 1'b0;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wvalid;
   logic        wready = 1'b0;
   logic [1:0]  bresp = 2'b00;
   logic        bvalid = 1'b0;
   logic        bready;
   logic        cpu_hold;
   logic        boot_done;
   logic        boot_error;

   uart_boot_loader #(
      .BASE_ADDR (BASE),
      .MAX_BYTES (MAXB),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .awaddr     (awaddr),
      .awvalid    (awvalid),
      .awready    (awready),
      .wdata      (wdata),
      .wstrb      (wstrb),
      .wvalid     (wvalid),
      .wready     (wready),
      .bresp      (bresp),
      .bvalid     (bvalid),
      .bready     (bready),
      .cpu_hold   (cpu_hold),
      .boot_done  (boot_done),
      .boot_error (boot_error)
   );

   always #5 clk = ~clk;

   // ---------------- AXI4-Lite slave model ----------------
   int          aw_delay  = 0;
   logic [1:0]  cfg_bresp = 2'b00;
   int          aw_wait = 0;
   int          aw_cnt  = 0;
   int          w_cnt   = 0;
   int          b_cnt   = 0;
   logic [63:0] aw_log [64];
   logic [63:0] wd_log [64];
   logic [7:0]  ws_log [64];

   // Slave outputs change on the falling edge, away from the DUT's sampling edge
   always @(negedge clk) begin
      awready <= awvalid && (aw_wait >= aw_delay);
      wready  <= wvalid;
      bvalid  <= (b_cnt < aw_cnt) && (b_cnt < w_cnt);
      bresp   <= cfg_bresp;
   end

   // Handshake logging on the active edge
   always @(posedge clk) begin
      if (awvalid && awready) begin
         aw_log[aw_cnt % 64] <= awaddr;
         aw_cnt  <= aw_cnt + 1;
         aw_wait <= 0;
      end else if (awvalid) begin
         aw_wait <= aw_wait + 1;
      end
      if (wvalid && wready) begin
         wd_log[w_cnt % 64] <= wdata;
         ws_log[w_cnt % 64] <= wstrb;
         w_cnt <= w_cnt + 1;
      end
      if (bvalid && bready) begin
         b_cnt <= b_cnt + 1;
      end
   end

   // ---------------- checking helpers ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_vec++;
         n_err++;
         $error("FAIL rx_timeout: byte %h not accepted (observed rx_ready=0, expected 1)", b);
      end else begin
         @(posedge clk);
      end
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] len);
      send(8'hA5);
      send(len[7:0]);
      send(len[15:8]);
      send(len[23:16]);
      send(len[31:24]);
   endtask

   task automatic wait_end();
      int t;
      t = 0;
      @(negedge clk);
      while (!(boot_done || boot_error) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         n_vec++;
         n_err++;
         $error("FAIL end_timeout: observed no boot_done/boot_error, expected one");
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      rst      = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_rx_ready_low", {63'd0, rx_ready}, 64'd0);
      check("rst_cpu_hold",     {63'd0, cpu_hold}, 64'd1);
      check("rst_boot_done",    {63'd0, boot_done}, 64'd0);
      check("rst_boot_error",   {63'd0, boot_error}, 64'd0);
      check("rst_awvalid",      {63'd0, awvalid}, 64'd0);
      check("rst_wvalid",       {63'd0, wvalid}, 64'd0);
      check("rst_bready",       {63'd0, bready}, 64'd0);
      check("rst_wstrb",        {56'd0, wstrb}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_rx_ready",    {63'd0, rx_ready}, 64'd1);

      // 1: full 8-byte word
      base = aw_cnt;
      send_hdr(32'd8);
      for (int i = 1; i <= 8; i++) send(8'(i));
      send(8'h08);
      wait_end();
      check("t1_aw_count",  64'(aw_cnt - base), 64'd1);
      check("t1_w_count",   64'(w_cnt - base), 64'd1);
      check("t1_awaddr",    aw_log[base % 64], BASE);
      check("t1_wdata",     wd_log[base % 64], 64'h0807060504030201);
      check("t1_wstrb",     {56'd0, ws_log[base % 64]}, 64'hFF);
      check("t1_boot_done", {63'd0, boot_done}, 64'd1);
      check("t1_cpu_hold",  {63'd0, cpu_hold}, 64'd0);
      check("t1_boot_err",  {63'd0, boot_error}, 64'd0);
      check("t1_rx_ready",  {63'd0, rx_ready}, 64'd0);

      // 2: partial last word
      do_reset();
      base = aw_cnt;
      send_hdr(32'd3);
      send(8'hAA); send(8'hBB); send(8'hCC);
      send(8'hDD);
      wait_end();
      check("t2_aw_count",  64'(aw_cnt - base), 64'd1);
      check("t2_wdata",     wd_log[base % 64], 64'h0000_0000_00CC_BBAA);
      check("t2_wstrb",     {56'd0, ws_log[base % 64]}, 64'h07);
      check("t2_boot_done", {63'd0, boot_done}, 64'd1);

      // 3: garbage before sync, zero-length frame
      do_reset();
      base = aw_cnt;
      send(8'h00); send(8'hFF); send(8'h5A);
      check("t3_still_hold", {63'd0, cpu_hold}, 64'd1);
      send_hdr(32'd0);
      send(8'h00);
      wait_end();
      check("t3_aw_count",  64'(aw_cnt - base), 64'd0);
      check("t3_boot_done", {63'd0, boot_done}, 64'd1);
      check("t3_cpu_hold",  {63'd0, cpu_hold}, 64'd0);

      // 4: delayed awready, error response
      do_reset();
      base      = aw_cnt;
      aw_delay  = 5;
      cfg_bresp = 2'b10;
      send_hdr(32'd2);
      send(8'h11); send(8'h22);
      wait_end();
      repeat (10) @(negedge clk);
      check("t4_aw_count",  64'(aw_cnt - base), 64'd1);
      check("t4_w_count",   64'(w_cnt - base), 64'd1);
      check("t4_awaddr",    aw_log[base % 64], BASE);
      check("t4_boot_err",  {63'd0, boot_error}, 64'd1);
      check("t4_cpu_hold",  {63'd0, cpu_hold}, 64'd1);
      check("t4_boot_done", {63'd0, boot_done}, 64'd0);
      aw_delay  = 0;
      cfg_bresp = 2'b00;

      // 5: two words, wrong checksum (payload xor is 00)
      do_reset();
      base = aw_cnt;
      send_hdr(32'd16);
      for (int i = 0; i < 16; i++) send(8'(i));
      send(8'hFF);
      wait_end();
      check("t5_aw_count",  64'(aw_cnt - base), 64'd2);
      check("t5_awaddr0",   aw_log[base % 64], BASE);
      check("t5_awaddr1",   aw_log[(base + 1) % 64], BASE + 64'd8);
      check("t5_wdata0",    wd_log[base % 64], 64'h0706050403020100);
      check("t5_wdata1",    wd_log[(base + 1) % 64], 64'h0F0E0D0C0B0A0908);
      check("t5_boot_err",  {63'd0, boot_error}, 64'd1);
      check("t5_boot_done", {63'd0, boot_done}, 64'd0);

      // 6: reset mid-DATA, then a clean frame
      do_reset();
      base = aw_cnt;
      send_hdr(32'd8);
      for (int i = 1; i <= 5; i++) send(8'(i));
      do_reset();
      repeat (5) @(negedge clk);
      check("t6_abort_aw",   64'(aw_cnt - base), 64'd0);
      check("t6_abort_hold", {63'd0, cpu_hold}, 64'd1);
      check("t6_abort_done", {63'd0, boot_done}, 64'd0);
      send_hdr(32'd4);
      send(8'h10); send(8'h20); send(8'h30); send(8'h40);
      send(8'h40);
      wait_end();
      check("t6_aw_count",  64'(aw_cnt - base), 64'd1);
      check("t6_awaddr",    aw_log[base % 64], BASE);
      check("t6_wdata",     wd_log[base % 64], 64'h0000_0000_4030_2010);
      check("t6_wstrb",     {56'd0, ws_log[base % 64]}, 64'h0F);
      check("t6_boot_done", {63'd0, boot_done}, 64'd1);

      // 7: length one above the maximum is rejected
      do_reset();
      base = aw_cnt;
      send_hdr(MAXB + 1);
      wait_end();
      check("t7_boot_err",  {63'd0, boot_error}, 64'd1);
      check("t7_aw_count",  64'(aw_cnt - base), 64'd0);

      // 8: length exactly the maximum is accepted (payload xor is 00)
      do_reset();
      base = aw_cnt;
      send_hdr(MAXB);
      for (int i = 0; i < 32; i++) send(8'(i));
      send(8'h00);
      wait_end();
      check("t8_aw_count",  64'(aw_cnt - base), 64'd4);
      check("t8_awaddr3",   aw_log[(base + 3) % 64], BASE + 64'd24);
      check("t8_wdata3",    wd_log[(base + 3) % 64], 64'h1F1E1D1C1B1A1918);
      check("t8_boot_done", {63'd0, boot_done}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
